// File: rtl/regfile_writeback_pkg.sv
// regfile_writeback_pkg: shared word width, zero-register index and writeback entry layout
package regfile_writeback_pkg;
  localparam int WORD = 64;
  localparam logic [4:0] XZR = 5'd31;
  typedef struct packed {
    logic [4:0]      rd;
    logic [WORD-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_bypass_match.sv
// wb_bypass_match: youngest-first search of pending writeback entries for one decode read port
// Ports: i_rd/i_data queue storage, i_head/i_pending live window, i_out_* output register,
//        i_addr read address; o_hit/o_data match result (zero on miss).
module wb_bypass_match import regfile_writeback_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic [DEPTH-1:0][4:0]       i_rd,
  input  logic [DEPTH-1:0][WIDTH-1:0] i_data,
  input  logic [AW-1:0]               i_head,
  input  logic [PW-1:0]               i_pending,
  input  logic                        i_out_vld,
  input  logic [4:0]                  i_out_rd,
  input  logic [WIDTH-1:0]            i_out_data,
  input  logic [4:0]                  i_addr,
  output logic                        o_hit,
  output logic [WIDTH-1:0]            o_data
);
  // Oldest first so each younger match overrides: output register, then head..tail-1.
  always_comb begin
    o_hit = i_out_vld && i_out_rd == i_addr;
    o_data = o_hit ? i_out_data : '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (PW'(j) < i_pending && i_rd[i_head + AW'(j)] == i_addr) begin
        o_hit = 1'b1;
        o_data = i_data[i_head + AW'(j)];
      end
    end
    if (i_addr == XZR) begin
      o_hit = 1'b0;
      o_data = '0;
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order queue of ALU/load results draining one write per cycle into regfile
// Ports: alu_*/mem_* valid/ready result channels (mem older on a tie), write_register/write_data/
//        RegWrite registered regfile write port, read_register1/2 decode addresses with
//        bypass_hit/bypass_data, pending queue occupancy (excludes the output register).
module regfile_writeback import regfile_writeback_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  output logic [4:0]       write_register,
  output logic [WIDTH-1:0] write_data,
  output logic             RegWrite,
  input  logic [4:0]       read_register1,
  input  logic [4:0]       read_register2,
  output logic             bypass_hit1,
  output logic             bypass_hit2,
  output logic [WIDTH-1:0] bypass_data1,
  output logic [WIDTH-1:0] bypass_data2,
  output logic [PW-1:0]    pending
);
  logic [DEPTH-1:0][4:0]       r_rd;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [AW-1:0]               r_head, r_tail;
  logic                        w_push_mem, w_push_alu, w_pop;
  // Ready ignores a same-cycle pop; alu only gets the last slot when mem is not competing.
  assign mem_ready = !reset && pending <= PW'(DEPTH - 1);
  assign alu_ready = !reset && (pending <= PW'(DEPTH - 2) || (pending == PW'(DEPTH - 1) && !mem_valid));
  // XZR results complete the handshake but are dropped.
  assign w_push_mem = mem_valid && mem_ready && mem_rd != XZR;
  assign w_push_alu = alu_valid && alu_ready && alu_rd != XZR;
  assign w_pop = pending != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      r_head <= '0;
      r_tail <= '0;
      RegWrite <= 1'b0;
      write_register <= '0;
      write_data <= '0;
    end else begin
      if (w_push_mem) begin
        r_rd[r_tail] <= mem_rd;
        r_data[r_tail] <= mem_data;
      end
      if (w_push_alu) begin
        r_rd[r_tail + AW'(w_push_mem)] <= alu_rd;
        r_data[r_tail + AW'(w_push_mem)] <= alu_data;
      end
      r_tail <= r_tail + AW'(w_push_mem) + AW'(w_push_alu);
      if (w_pop) begin
        r_head <= r_head + AW'(1);
        write_register <= r_rd[r_head];
        write_data <= r_data[r_head];
      end
      RegWrite <= w_pop;
      pending <= pending + PW'(w_push_mem) + PW'(w_push_alu) - PW'(w_pop);
    end
  end
  wb_bypass_match #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_match1 (
    .i_rd(r_rd), .i_data(r_data), .i_head(r_head), .i_pending(pending),
    .i_out_vld(RegWrite), .i_out_rd(write_register), .i_out_data(write_data),
    .i_addr(read_register1), .o_hit(bypass_hit1), .o_data(bypass_data1)
  );
  wb_bypass_match #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_match2 (
    .i_rd(r_rd), .i_data(r_data), .i_head(r_head), .i_pending(pending),
    .i_out_vld(RegWrite), .i_out_rd(write_register), .i_out_data(write_data),
    .i_addr(read_register2), .o_hit(bypass_hit2), .o_data(bypass_data2)
  );
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed checks of queueing, drain order, ready limits, bypass, XZR and reset
module tb_regfile_writeback;
  logic clk = 1'b0;
  logic reset;
  logic alu_valid, alu_ready, mem_valid, mem_ready, RegWrite;
  logic [4:0] alu_rd, mem_rd, write_register, read_register1, read_register2;
  logic [63:0] alu_data, mem_data, write_data, bypass_data1, bypass_data2;
  logic bypass_hit1, bypass_hit2;
  logic [2:0] pending;
  logic [63:0] rf [32] = '{default: 64'd0};
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (RegWrite) rf[write_register] <= write_data;
  regfile_writeback dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .write_register(write_register), .write_data(write_data), .RegWrite(RegWrite),
    .read_register1(read_register1), .read_register2(read_register2),
    .bypass_hit1(bypass_hit1), .bypass_hit2(bypass_hit2),
    .bypass_data1(bypass_data1), .bypass_data2(bypass_data2), .pending(pending)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic mv, input logic [4:0] mr, input logic [63:0] md,
                       input logic av, input logic [4:0] ar, input logic [63:0] ad);
    mem_valid = mv; mem_rd = mr; mem_data = md;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    #1;
  endtask
  initial begin
    reset = 1'b1;
    read_register1 = 5'd0;
    read_register2 = 5'd0;
    offer(0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_pending", pending, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wreg", write_register, 0);
    chk("rst_wdata", write_data, 0);
    reset = 1'b0;
    #1;
    chk("idle_mem_ready", mem_ready, 1);
    chk("idle_alu_ready", alu_ready, 1);
    chk("idle_hit1", bypass_hit1, 0);
    // single ALU write
    read_register1 = 5'd13;
    offer(0, 0, 0, 1, 13, 4783);
    step();
    offer(0, 0, 0, 0, 0, 0);
    chk("t1_pending", pending, 1);
    chk("t1_we_early", RegWrite, 0);
    chk("t1_hit_q", bypass_hit1, 1);
    chk("t1_bdata_q", bypass_data1, 4783);
    step();
    chk("t1_we", RegWrite, 1);
    chk("t1_wreg", write_register, 13);
    chk("t1_wdata", write_data, 4783);
    chk("t1_pending0", pending, 0);
    chk("t1_hit_out", bypass_hit1, 1);
    step();
    chk("t1_we_drop", RegWrite, 0);
    chk("t1_wreg_hold", write_register, 13);
    chk("t1_wdata_hold", write_data, 4783);
    chk("t1_hit_gone", bypass_hit1, 0);
    chk("t1_bdata_gone", bypass_data1, 0);
    chk("t1_rf13", rf[13], 4783);
    // simultaneous sources: mem is older
    offer(1, 9, 3987, 1, 10, 55);
    step();
    offer(0, 0, 0, 0, 0, 0);
    chk("t2_pending", pending, 2);
    step();
    chk("t2_we1", RegWrite, 1);
    chk("t2_wreg1", write_register, 9);
    chk("t2_wdata1", write_data, 3987);
    step();
    chk("t2_we2", RegWrite, 1);
    chk("t2_wreg2", write_register, 10);
    chk("t2_wdata2", write_data, 55);
    step();
    chk("t2_we_drop", RegWrite, 0);
    chk("t2_rf9", rf[9], 3987);
    chk("t2_rf10", rf[10], 55);
    // fill and ready limits at pending = DEPTH-1
    offer(1, 1, 11, 1, 2, 12);
    step();
    offer(1, 3, 13, 1, 4, 14);
    chk("t3_alu_ready_p2", alu_ready, 1);
    step();
    chk("t3_pending3", pending, 3);
    chk("t3_wreg1", write_register, 1);
    offer(1, 6, 16, 1, 7, 17);
    chk("t3_mem_ready_p3", mem_ready, 1);
    chk("t3_alu_ready_p3", alu_ready, 0);
    step();
    offer(0, 0, 0, 0, 0, 0);
    chk("t3_pending_hold", pending, 3);
    chk("t3_wreg2", write_register, 2);
    chk("t3_alu_ready_nomem", alu_ready, 1);
    step();
    chk("t3_wreg3", write_register, 3);
    chk("t3_pending2", pending, 2);
    step();
    chk("t3_wreg4", write_register, 4);
    chk("t3_pending1", pending, 1);
    step();
    chk("t3_wreg6", write_register, 6);
    chk("t3_wdata6", write_data, 16);
    chk("t3_pending0", pending, 0);
    step();
    chk("t3_we_drop", RegWrite, 0);
    chk("t3_rf6", rf[6], 16);
    chk("t3_rf7_refused", rf[7], 0);
    // bypass youngest-match ordering
    read_register1 = 5'd5;
    read_register2 = 5'd6;
    offer(1, 5, 100, 1, 5, 200);
    step();
    offer(0, 0, 0, 0, 0, 0);
    chk("t4_hit_qq", bypass_hit1, 1);
    chk("t4_data_qq", bypass_data1, 200);
    chk("t4_hit2_miss", bypass_hit2, 0);
    step();
    chk("t4_wdata100", write_data, 100);
    chk("t4_hit_oq", bypass_hit1, 1);
    chk("t4_data_oq", bypass_data1, 200);
    step();
    chk("t4_wdata200", write_data, 200);
    chk("t4_hit_o", bypass_hit1, 1);
    chk("t4_data_o", bypass_data1, 200);
    step();
    chk("t4_hit_miss", bypass_hit1, 0);
    chk("t4_data_miss", bypass_data1, 0);
    // XZR
    read_register1 = 5'd31;
    offer(0, 0, 0, 1, 31, 77);
    chk("t5_alu_ready", alu_ready, 1);
    step();
    offer(0, 0, 0, 0, 0, 0);
    chk("t5_pending", pending, 0);
    chk("t5_we", RegWrite, 0);
    chk("t5_hit31", bypass_hit1, 0);
    step();
    chk("t5_we_later", RegWrite, 0);
    chk("t5_wreg_hold", write_register, 5);
    // reset mid-drain
    read_register1 = 5'd22;
    offer(1, 20, 1, 1, 21, 2);
    step();
    offer(1, 22, 3, 1, 23, 4);
    step();
    offer(0, 0, 0, 0, 0, 0);
    chk("t6_pending3", pending, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t6_pending0", pending, 0);
    chk("t6_we0", RegWrite, 0);
    chk("t6_hit_flushed", bypass_hit1, 0);
    step();
    chk("t6_we_after1", RegWrite, 0);
    step();
    chk("t6_we_after2", RegWrite, 0);
    chk("t6_rf21", rf[21], 0);
    chk("t6_rf22", rf[22], 0);
    chk("t6_rf23", rf[23], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side initiator for `regfile`. It accepts register results from the ALU and memory stages through valid/ready handshakes and holds them in a small in-order queue. It drains one entry per cycle onto the register file write port (`write_register`, `write_data`, `RegWrite`). While results are pending, it supplies bypass data to decode reads so that decode never observes stale register contents.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `WIDTH`, `` `WORD `` (64), data width, from `definitions.vh`
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `alu_valid` in 1, `alu_ready` out 1, `alu_rd` in 5, `alu_data` in WIDTH: ALU result channel
- `mem_valid` in 1, `mem_ready` out 1, `mem_rd` in 5, `mem_data` in WIDTH: load result channel
- `write_register` out 5, `write_data` out WIDTH, `RegWrite` out 1: drive the `regfile` write port; registered
- `read_register1`, `read_register2` in 5: decode read addresses, the same nets that feed `regfile`
- `bypass_hit1`, `bypass_hit2` out 1, `bypass_data1`, `bypass_data2` out WIDTH: combinational bypass
- `pending` out $clog2(DEPTH)+1: queue occupancy; excludes the output register

## Operation
- A transfer occurs when valid and ready are both high at a rising edge. Data and rd must be stable while valid is high.
- Ready depends only on registered `pending` and on `mem_valid`. A pop in the same cycle does not create space:
  - `mem_ready` = `pending` ≤ DEPTH-1.
  - `alu_ready` = `pending` ≤ DEPTH-2, or (`pending` = DEPTH-1 and `mem_valid` = 0).
- Both ready outputs are 0 while `reset` = 1.
- When both channels are accepted in the same cycle, memory is older. The mem entry is enqueued first, then the ALU entry.
- rd = 31 (XZR) is accepted through the handshake but not enqueued, so it never reaches the write port or the bypass.
- Drain: if `pending` > 0 at an edge, the head is popped into the output register and `RegWrite` is 1 for the following cycle. Otherwise `RegWrite` is 0.
- When `RegWrite` = 0, `write_register` and `write_data` hold their last values.
- Bypass for each read port:
  - Search the output register (while `RegWrite` = 1) and all queue entries for a matching rd.
  - The youngest match wins: tail-1 first, the output register last.
  - On a miss, `hit` = 0 and `data` = 0.
  - Address 31 never hits.
- Pointers wrap modulo DEPTH. Full is `pending` = DEPTH and empty is `pending` = 0. The pointer and count update applies push(es) and pop in the same edge.

## Timing
- Reset values: `pending` 0, head/tail 0, `RegWrite` 0, `write_register` 0, `write_data` 0, bypass hits 0.
- Reset asserted mid-operation discards all queued and in-flight entries at that edge. No write is issued after reset.
- Latency: an entry accepted at edge k, with an empty queue, is presented with `RegWrite` = 1 from edge k+1 to edge k+2. `regfile` commits it on its write clock during that window.
- Each queued entry adds one cycle of latency. Sustained throughput is one write per cycle.
- Bypass is visible in the same cycle the entry becomes queued (from edge k). It remains valid until the cycle after `RegWrite` drops for that entry.
- Simultaneous push and pop when full:
  - The pop proceeds.
  - The push is refused, because ready was already 0.

## Structure
- Shared package/header (`definitions.vh`):
  - `WORD`
  - `XZR` = 5'd31
  - the entry record layout {rd[4:0], data[WORD-1:0]}
- One sub-module, `wb_bypass_match`: combinational youngest-match search over the entry array plus the output register. It is instanced twice, once per read port.

## Test plan
- Single ALU write: `alu_rd` = 13, `alu_data` = 4783 at edge 0.
  - → `RegWrite` = 1, `write_register` = 13, `write_data` = 4783 during cycle 1 only.
  - → a subsequent `regfile` read of 13 returns 4783.
- Simultaneous sources: mem rd = 9 / 3987 and alu rd = 10 / 55 at one edge.
  - → writes issue in order: reg 9 then reg 10, on consecutive cycles.
- Fill to DEPTH = 4 with no drain stall, then offer both channels at `pending` = 3.
  - → `mem_ready` = 1 and `alu_ready` = 0.
  - → only the mem entry enters.
  - → `pending` never exceeds 4.
- Bypass ordering: enqueue rd 5 / 100, then rd 5 / 200, with `read_register1` = 5.
  - → `bypass_hit1` = 1 with data 200 until the second write is retired.
  - → miss after that.
- XZR: alu rd = 31, data = 77.
  - → handshake completes.
  - → `pending` stays 0, `RegWrite` stays 0, and no bypass hit on read address 31.
- Reset mid-drain: 3 entries pending, assert `reset` for one edge.
  - → `pending` = 0 and `RegWrite` = 0 next cycle.
  - → no further writes.
